// File: rtl/jk_bank_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver_pkg
// Description : Shared types and excitation encodings for the JK bank driver.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_bank_driver_pkg;

    // Controller states; width fixed at 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Retry counter; MAX_RETRY is limited to 0..15, so it never saturates.
    typedef logic [3:0] retry_t;

    // Per-bit excitation encodings, packed as {J, K}.
    localparam logic [1:0] c_exc_hold   = 2'b00;
    localparam logic [1:0] c_exc_set    = 2'b10;
    localparam logic [1:0] c_exc_reset  = 2'b01;
    localparam logic [1:0] c_exc_toggle = 2'b11;

    // JK excitation for one bit: present state q, desired next state d.
    // Hold-case don't-cares resolve to J=K=0.
    function automatic logic [1:0] excite_bit(input logic q, input logic d,
                                              input logic use_toggle);
        logic [1:0] w_jk;
        if (q == d)
            w_jk = c_exc_hold;
        else if (use_toggle)
            w_jk = c_exc_toggle;
        else if (d)
            w_jk = c_exc_set;
        else
            w_jk = c_exc_reset;
        return w_jk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
// Module      : jk_excite
// Description : Combinational WIDTH-wide JK excitation encoder. Produces the
//               J/K drive that moves each bit from present q to target d.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_excite
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int USE_TOGGLE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    localparam logic c_use_toggle = (USE_TOGGLE != 0);

    // One independent encoder per flip-flop of the bank.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [1:0] w_jk;
            assign w_jk  = excite_bit(q[gi], d[gi], c_use_toggle);
            assign j[gi] = w_jk[1];
            assign k[gi] = w_jk[0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver
// Description : Accepts a target pattern for a JK flip-flop bank, drives one
//               J/K update cycle, verifies the bank Q, retries up to
//               MAX_RETRY times and reports done or err as one-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_RETRY  = 3,
    parameter int USE_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam retry_t c_max_retry = retry_t'(MAX_RETRY);

    state_t           r_state;
    retry_t           r_retry;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_err;

    logic [WIDTH-1:0] w_exc_d;
    logic [WIDTH-1:0] w_exc_j;
    logic [WIDTH-1:0] w_exc_k;
    logic             w_handshake;
    logic             w_match;

    // The single encoder serves both the first drive (target straight from
    // the input port) and retries (target from the latched register).
    assign w_exc_d     = (r_state == ST_IDLE) ? tgt_data : r_target;
    assign tgt_ready   = (r_state == ST_IDLE) && rst;
    assign w_handshake = tgt_valid && tgt_ready;
    assign w_match     = (q_fb == r_target);

    jk_excite #(
        .WIDTH      (WIDTH),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_excite (
        .q (q_fb),
        .d (w_exc_d),
        .j (w_exc_j),
        .k (w_exc_k)
    );

    // Controller FSM with registered J/K drive and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_retry  <= '0;
            r_target <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_target <= tgt_data;
                        r_j      <= w_exc_j;
                        r_k      <= w_exc_k;
                        r_retry  <= '0;
                        r_state  <= ST_DRIVE;
                    end else begin
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                ST_DRIVE: begin
                    // Bank samples J/K at this edge; release the drive.
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (r_retry < c_max_retry) begin
                        r_retry <= r_retry + retry_t'(1);
                        r_j     <= w_exc_j;
                        r_k     <= w_exc_k;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign j    = r_j;
    assign k    = r_k;
    assign done = r_done;
    assign err  = r_err;
    assign busy = (r_state == ST_DRIVE) || (r_state == ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_driver
// Description : Self-checking bench for jk_bank_driver. Two instances (set/
//               reset and toggle excitation) share stimulus; each drives its
//               own behavioural JK bank with optional stuck-at-0 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

    localparam int WIDTH     = 4;
    localparam int MAX_RETRY = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tgt_valid = 1'b0;
    logic [WIDTH-1:0] tgt_data = '0;
    logic [WIDTH-1:0] q_s = '0;
    logic [WIDTH-1:0] q_t = '0;
    logic [WIDTH-1:0] stuck = '0;

    logic [WIDTH-1:0] j_s, k_s, j_t, k_t;
    logic             ready_s, busy_s, done_s, err_s;
    logic             ready_t, busy_t, done_t, err_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] qexp = '0;

    always #5 clk = ~clk;

    jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .USE_TOGGLE(0)) u_dut_s (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(ready_s),
        .tgt_data(tgt_data), .q_fb(q_s), .j(j_s), .k(k_s),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .USE_TOGGLE(1)) u_dut_t (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(ready_t),
        .tgt_data(tgt_data), .q_fb(q_t), .j(j_t), .k(k_t),
        .busy(busy_t), .done(done_t), .err(err_t)
    );

    // Behavioural JK banks: Q+ = J&~Q | ~K&Q, stuck bits forced to 0.
    always @(posedge clk) begin
        q_s <= ((j_s & ~q_s) | (~k_s & q_s)) & ~stuck;
        q_t <= ((j_t & ~q_t) | (~k_t & q_t)) & ~stuck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference excitation, packed {J, K}.
    function automatic logic [7:0] want_jk(input logic [3:0] q, input logic [3:0] d,
                                           input bit tog);
        logic [3:0] w_chg;
        w_chg = q ^ d;
        if (tog) return {w_chg, w_chg};
        return {w_chg & d, w_chg & q};
    endfunction

    // One idle cycle: ready, no activity.
    task automatic idle_check();
        @(negedge clk);
        chk("idle_status", {ready_s, ready_t, busy_s, busy_t, done_s, done_t, err_s, err_t},
            8'b1100_0000);
        chk("idle_jk", {j_s, k_s, j_t, k_t}, 16'h0);
    endtask

    // Full job entered at a negedge of an IDLE (or done/err) cycle; ends at the
    // negedge of the done/err cycle so a follow-up job is back-to-back.
    task automatic run_job(input logic [3:0] tgt);
        bit ok;
        ok = 1'b0;
        tgt_valid = 1'b1;
        tgt_data  = tgt;
        chk("accept_ready", {ready_s, ready_t}, 2'b11);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        tgt_data  = 4'($urandom);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            @(negedge clk);
            chk("drive_jk_s", {j_s, k_s}, want_jk(qexp, tgt, 1'b0));
            chk("drive_jk_t", {j_t, k_t}, want_jk(qexp, tgt, 1'b1));
            chk("drive_status", {busy_s, busy_t, ready_s, ready_t, done_s, done_t, err_s, err_t},
                8'b1100_0000);
            qexp = tgt & ~stuck;
            @(negedge clk);
            chk("check_q", {q_s, q_t}, {qexp, qexp});
            chk("check_jk", {j_s, k_s, j_t, k_t}, 16'h0);
            chk("check_status", {busy_s, busy_t, done_s, done_t, err_s, err_t}, 6'b110000);
            if (qexp == tgt) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        chk("result_done", {done_s, done_t}, ok ? 2'b11 : 2'b00);
        chk("result_err", {err_s, err_t}, ok ? 2'b00 : 2'b11);
        chk("result_idle", {busy_s, busy_t, ready_s, ready_t}, 4'b0011);
        chk("result_jk", {j_s, k_s, j_t, k_t}, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles.
        repeat (2) begin
            @(negedge clk);
            chk("rst_status", {ready_s, ready_t, busy_s, busy_t, done_s, done_t, err_s, err_t},
                8'h00);
            chk("rst_jk", {j_s, k_s, j_t, k_t}, 16'h0);
        end
        rst = 1'b1;
        idle_check();

        // Directed sequence: set, mixed change, no-change + back-to-back.
        run_job(4'b1010);
        idle_check();
        run_job(4'b0110);
        idle_check();
        run_job(4'b0110);
        run_job(4'b0000);
        idle_check();

        // Stuck-at-0 bit 0: all retries fail.
        stuck = 4'b0001;
        idle_check();
        run_job(4'b0001);
        idle_check();
        stuck = 4'b0000;
        idle_check();

        // Reset during CHECK aborts the job silently.
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_jk", {j_s, k_s, j_t, k_t}, 16'h0);
        chk("abort_status", {busy_s, busy_t, ready_s, ready_t, done_s, done_t, err_s, err_t},
            8'h00);
        qexp = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("abort_q", {q_s, q_t}, {qexp, qexp});
        rst = 1'b1;
        repeat (3) idle_check();
        run_job(4'b0011);

        // Randomized jobs with random gaps and occasional stuck bits.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) idle_check();
            if ($urandom_range(0, 4) == 0) begin
                stuck = 4'($urandom);
                qexp  = qexp & ~stuck;
                idle_check();
            end
            run_job(4'($urandom));
            stuck = '0;
        end
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Excitation-side controller for a bank of WIDTH JK flip-flops. It accepts a target bit pattern over a valid/ready handshake.
- It reads the bank's present Q, converts present/target into J/K through the JK excitation table, and drives one update cycle.
- It then checks that Q reached the target, retries up to MAX_RETRY times, and reports done or err.
- It is the inverse of the JK flip-flop's characteristic function: it decides J/K from the desired next state. It sits between control logic and any JK-based register/counter bank.

Parameters:
WIDTH, 4, number of JK flip-flops in the driven bank
MAX_RETRY, 3, extra drive attempts after the first before err is raised (0..15)
USE_TOGGLE, 0, 0 = set/reset excitation for changing bits; 1 = J=K=1 (toggle) for changing bits

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  asynchronous, active-low reset
tgt_valid  input  1  target pattern offered
tgt_ready  output  1  block can accept target; high only in IDLE with rst high
tgt_data  input  WIDTH  desired bank state; captured on tgt_valid && tgt_ready
q_fb  input  WIDTH  present Q of the JK bank
j  output  WIDTH  registered J drive to bank
k  output  WIDTH  registered K drive to bank
busy  output  1  high in DRIVE or CHECK
done  output  1  one-cycle pulse: bank matched target
err  output  1  one-cycle pulse: retries exhausted without match

Behaviour:
- Reset (rst low, async): state=IDLE, j=k=0, done=err=0, retry count=0, target register=0, tgt_ready=0. Effect is immediate, including mid-DRIVE/CHECK. No done/err is produced for an aborted job.
- Excitation per bit (present q, target d):
  - 0->0 and 1->1: J=0, K=0 (hold; don't-cares resolved to 0).
  - 0->1: J=1, K=0 (J=K=1 if USE_TOGGLE).
  - 1->0: J=0, K=1 (J=K=1 if USE_TOGGLE).
- FSM states: IDLE, DRIVE, CHECK.
- IDLE: tgt_ready=1.
  - On handshake: latch tgt_data; register j/k = excite(q_fb, tgt_data); retry count=0; go DRIVE.
  - Otherwise j=k=0.
- DRIVE: lasts exactly one cycle with j/k stable; the bank captures them at the closing edge. At that edge: j=k=0, go CHECK.
- CHECK: one cycle; the bank Q settles. At the closing edge, compare q_fb against the latched target:
  - Match: done=1 for one cycle, go IDLE.
  - Mismatch and count<MAX_RETRY: count++, j/k = excite(q_fb, target), go DRIVE.
  - Mismatch and count==MAX_RETRY: err=1 for one cycle, go IDLE.
- Latency: handshake at edge E0 -> j/k valid E0..E1 -> CHECK E1..E2 -> done high E2..E3. Success on the first attempt = 2 cycles. Each retry adds 2 cycles.
- done and err are mutually exclusive and never asserted in the same cycle as j/k nonzero.
- tgt_ready is high in the done/err cycle (state is IDLE), so back-to-back jobs are allowed. A new target accepted in the done cycle starts DRIVE at the next edge.
- Target equal to present Q: j=k=0 for the DRIVE cycle, done after 2 cycles; still a full job.
- tgt_data and q_fb changes outside the capture/compare edges are ignored.
- Retry count width: 4 bits; saturation impossible given the MAX_RETRY range.

Decomposition:
- Package jk_bank_driver_pkg: FSM state enum (IDLE, DRIVE, CHECK), 4-bit retry count type, excitation-encoding localparams for hold/set/reset/toggle.
- Sub-module jk_excite: combinational WIDTH-wide excitation encoder; inputs q, d; parameter USE_TOGGLE; outputs j, k. Instanced once and used for both first drive and retries.

Test Plan:
- Bench model: behavioural WIDTH=4 JK bank, reset to 0000, fed by j/k, q_fb = bank Q.
1. Hold rst low 2 cycles then release -> j=k=0000, done=err=0, busy=0; tgt_ready=0 during reset, 1 after.
2. Q=0000, send target 1010 -> one DRIVE cycle with j=1010, k=0000; done pulses 2 cycles after accept; Q=1010.
3. Q=1010, target 0110 -> j=0100, k=1000; done after 2 cycles; Q=0110. Repeat with USE_TOGGLE=1 -> j=k=1100.
4. Q=0110, target 0110 -> j=k=0000 in DRIVE, done after 2 cycles. Immediately send 0000 in the done cycle -> accepted, completes in 2 more cycles.
5. Bank bit0 stuck at 0, target 0001, MAX_RETRY=3 -> four DRIVE cycles each with j=0001; err pulses 8 cycles after accept; done never asserts.
6. Target 1111 accepted, pull rst low during CHECK -> j=k=0, busy=0 immediately. No done/err after release; next job 0011 completes normally.
